// File: rtl/engine_sequencer_if.sv
// Handshake bundle between the engine sequencer (master) and the gain
// stage, the DSP pipeline bank and the output mixer (slave side).
interface engine_sequencer_if #(
    parameter int data_width  = 16,
    parameter int n_channels  = 2,
    parameter int n_pipelines = 2
);
    localparam int chan_w = $clog2(n_channels) + 1;

    // Gain stage handshake
    logic                   gain_req;
    logic [data_width-1:0]  gain_sample;
    logic                   gain_done;
    logic [data_width-1:0]  gain_result;

    // Pipeline bank
    logic                   pipeline_tick;
    logic [data_width-1:0]  pipeline_in;
    logic [chan_w-1:0]      pipeline_chan;
    logic [n_pipelines-1:0] pipeline_ready;
    logic [n_pipelines-1:0] pipeline_enable;

    // Mixer handshake
    logic                   mix_req;
    logic                   mix_done;
    logic [data_width-1:0]  mix_result;

    modport master (
        output gain_req, gain_sample, pipeline_tick, pipeline_in, pipeline_chan, mix_req,
        input  gain_done, gain_result, pipeline_ready, pipeline_enable, mix_done, mix_result
    );

    modport slave (
        input  gain_req, gain_sample, pipeline_tick, pipeline_in, pipeline_chan, mix_req,
        output gain_done, gain_result, pipeline_ready, pipeline_enable, mix_done, mix_result
    );
endinterface

// File: rtl/engine_sequencer.sv
// Engine sequencer: walks each channel of a captured frame through gain,
// the pipeline bank and the mixer, with a PROCESS watchdog that falls back
// to the dry (amplified) sample, overrun counting and frame completion stats.
module engine_sequencer #(
    parameter int data_width     = 16,
    parameter int n_channels     = 2,
    parameter int n_pipelines    = 2,
    parameter int timeout_cycles = 4096
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [n_channels*data_width-1:0] in_samples,
    input  logic                             sample_valid,
    output logic [n_channels*data_width-1:0] out_samples,
    output logic                             out_valid,
    output logic                             ready,
    engine_sequencer_if.master               eng,
    output logic                             timeout_flag,
    output logic [7:0]                       overrun_count,
    input  logic                             clear_flags,
    output logic [31:0]                      sample_ctr,
    output logic [2:0]                       state_out
);
    localparam int chan_w  = $clog2(n_channels) + 1;
    localparam int frame_w = n_channels * data_width;
    localparam int wd_w    = $clog2(timeout_cycles);

    localparam logic [wd_w-1:0]   wd_max    = wd_w'(timeout_cycles - 1);
    localparam logic [chan_w-1:0] last_chan = chan_w'(n_channels - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GAIN    = 3'd1,
        TICK    = 3'd2,
        SETTLE  = 3'd3,
        PROCESS = 3'd4,
        MIX     = 3'd5,
        NEXT    = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t                state_q,       state_d;
    logic [frame_w-1:0]    frame_q,       frame_d;
    logic [frame_w-1:0]    stage_q,       stage_d;
    logic [frame_w-1:0]    out_q,         out_d;
    logic [chan_w-1:0]     chan_q,        chan_d;
    logic [data_width-1:0] amped_q,       amped_d;
    logic [data_width-1:0] result_q,      result_d;
    logic [wd_w-1:0]       wd_q,          wd_d;
    logic                  out_valid_q,   out_valid_d;
    logic                  gain_req_q,    gain_req_d;
    logic                  mix_req_q,     mix_req_d;
    logic                  timeout_q,     timeout_d;
    logic [7:0]            overrun_q,     overrun_d;
    logic [31:0]           ctr_q,         ctr_d;

    logic                  all_ok;
    logic                  timeout_event;
    logic                  overrun_event;
    logic [data_width-1:0] cur_sample;

    // Raw sample of the current channel, selected from the captured frame
    always_comb begin
        cur_sample = '0;
        for (int k = 0; k < n_channels; k++) begin
            if (chan_w'(k) == chan_q) begin
                cur_sample = frame_q[k*data_width +: data_width];
            end
        end
    end

    // Next-state, datapath and flag logic for the channel sequencer
    always_comb begin
        // NOTE: every variable gets a default before the case statement so
        // that no path leaves it unassigned, which would infer a latch.
        state_d       = state_q;
        frame_d       = frame_q;
        stage_d       = stage_q;
        out_d         = out_q;
        chan_d        = chan_q;
        amped_d       = amped_q;
        result_d      = result_q;
        wd_d          = wd_q;
        out_valid_d   = 1'b0;
        gain_req_d    = 1'b0;
        mix_req_d     = 1'b0;
        ctr_d         = ctr_q;
        timeout_event = 1'b0;

        // Disabled pipelines count as ready; none enabled means always ok
        all_ok = &(eng.pipeline_ready | ~eng.pipeline_enable);

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    frame_d    = in_samples;
                    chan_d     = '0;
                    gain_req_d = 1'b1;
                    state_d    = GAIN;
                end
            end
            GAIN: begin
                if (eng.gain_done) begin
                    amped_d = eng.gain_result;
                    state_d = TICK;
                end
            end
            TICK: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                // Pipelines drop ready a cycle after the tick; skip that cycle
                wd_d    = '0;
                state_d = PROCESS;
            end
            PROCESS: begin
                if (all_ok) begin
                    mix_req_d = 1'b1;
                    state_d   = MIX;
                end else if (wd_q == wd_max) begin
                    result_d      = amped_q;
                    timeout_event = 1'b1;
                    state_d       = NEXT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            MIX: begin
                if (eng.mix_done) begin
                    result_d = eng.mix_result;
                    state_d  = NEXT;
                end
            end
            NEXT: begin
                for (int k = 0; k < n_channels; k++) begin
                    if (chan_w'(k) == chan_q) begin
                        stage_d[k*data_width +: data_width] = result_q;
                    end
                end
                if (chan_q == last_chan) begin
                    state_d = DONE;
                end else begin
                    chan_d     = chan_q + 1'b1;
                    gain_req_d = 1'b1;
                    state_d    = GAIN;
                end
            end
            DONE: begin
                out_d       = stage_q;
                out_valid_d = 1'b1;
                ctr_d       = ctr_q + 32'd1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A frame strobe outside IDLE is dropped; the frame in flight continues
        overrun_event = sample_valid && (state_q != IDLE);

        // Events take priority over a simultaneous clear
        if (timeout_event) begin
            timeout_d = 1'b1;
        end else if (clear_flags) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end

        if (overrun_event) begin
            if (clear_flags) begin
                overrun_d = 8'd1;
            end else if (overrun_q == 8'hFF) begin
                overrun_d = overrun_q;
            end else begin
                overrun_d = overrun_q + 8'd1;
            end
        end else if (clear_flags) begin
            overrun_d = '0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        if (!reset) begin
            state_q     <= IDLE;
            // NOTE: staging and output frames are cleared too, so an aborted
            // frame never leaves partial channel data visible.
            frame_q     <= '0;
            stage_q     <= '0;
            out_q       <= '0;
            chan_q      <= '0;
            amped_q     <= '0;
            result_q    <= '0;
            wd_q        <= '0;
            out_valid_q <= 1'b0;
            gain_req_q  <= 1'b0;
            mix_req_q   <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= '0;
            ctr_q       <= '0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            stage_q     <= stage_d;
            out_q       <= out_d;
            chan_q      <= chan_d;
            amped_q     <= amped_d;
            result_q    <= result_d;
            wd_q        <= wd_d;
            out_valid_q <= out_valid_d;
            gain_req_q  <= gain_req_d;
            mix_req_q   <= mix_req_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            ctr_q       <= ctr_d;
        end
    end

    assign eng.gain_req      = gain_req_q;
    assign eng.gain_sample   = cur_sample;
    assign eng.pipeline_tick = (state_q == TICK);
    assign eng.pipeline_in   = amped_q;
    assign eng.pipeline_chan = chan_q;
    assign eng.mix_req       = mix_req_q;

    assign out_samples   = out_q;
    assign out_valid     = out_valid_q;
    assign ready         = (state_q == IDLE);
    assign timeout_flag  = timeout_q;
    assign overrun_count = overrun_q;
    assign sample_ctr    = ctr_q;
    assign state_out     = state_q;
endmodule

// File: tb/tb_engine_sequencer.sv
// Directed bench for engine_sequencer: 2 channels, 2 pipelines, 8-cycle
// watchdog; gain and mixer stubs answer combinationally to each request.
module tb_engine_sequencer;
    localparam int dw = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_samples;
    logic        sample_valid;
    logic [31:0] out_samples;
    logic        out_valid;
    logic        ready;
    logic        timeout_flag;
    logic [7:0]  overrun_count;
    logic        clear_flags;
    logic [31:0] sample_ctr;
    logic [2:0]  state_out;

    logic [dw-1:0] gain_xor;
    logic [dw-1:0] mix_xor;
    logic [1:0]    rdy_val;
    logic [1:0]    en_val;
    logic          stall_ch1;

    int n_checks = 0;
    int n_errors = 0;
    int mix_cnt  = 0;
    int proc_cnt = 0;

    engine_sequencer_if #(.data_width(dw), .n_channels(2), .n_pipelines(2)) eng_if ();

    engine_sequencer #(
        .data_width(dw), .n_channels(2), .n_pipelines(2), .timeout_cycles(8)
    ) dut (
        .clk(clk), .reset(reset), .in_samples(in_samples), .sample_valid(sample_valid),
        .out_samples(out_samples), .out_valid(out_valid), .ready(ready), .eng(eng_if),
        .timeout_flag(timeout_flag), .overrun_count(overrun_count), .clear_flags(clear_flags),
        .sample_ctr(sample_ctr), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Stubs: gain and mixer answer within the request cycle with an XOR tweak
    assign eng_if.gain_done       = eng_if.gain_req;
    assign eng_if.gain_result     = eng_if.gain_sample ^ gain_xor;
    assign eng_if.mix_done        = eng_if.mix_req;
    assign eng_if.mix_result      = eng_if.pipeline_in ^ mix_xor;
    assign eng_if.pipeline_enable = en_val;
    assign eng_if.pipeline_ready  = (stall_ch1 && eng_if.pipeline_chan == 2'd1) ? 2'b10 : rdy_val;

    // Event counters for mix requests and cycles spent in PROCESS
    always @(posedge clk) begin
        if (eng_if.mix_req) mix_cnt <= mix_cnt + 1;
        if (state_out == 3'd4) proc_cnt <= proc_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one frame and count cycles from the accepting edge to out_valid
    task automatic run_frame(input logic [31:0] frame, output int lat);
        in_samples   = frame;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check("wait_ready", ready, 1'b1);
    endtask

    initial begin
        int lat;
        int mix0;
        int proc0;
        int n;

        reset        = 1'b0;
        in_samples   = '0;
        sample_valid = 1'b0;
        clear_flags  = 1'b0;
        gain_xor     = '0;
        mix_xor      = '0;
        rdy_val      = 2'b11;
        en_val       = 2'b11;
        stall_ch1    = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_state",   state_out, 3'd0);
        check("rst_ready",   ready, 1'b1);
        check("rst_out",     out_samples, 32'h0);
        check("rst_valid",   out_valid, 1'b0);
        check("rst_gainreq", eng_if.gain_req, 1'b0);
        check("rst_mixreq",  eng_if.mix_req, 1'b0);
        check("rst_tick",    eng_if.pipeline_tick, 1'b0);
        check("rst_tmo",     timeout_flag, 1'b0);
        check("rst_ovr",     overrun_count, 8'd0);
        check("rst_ctr",     sample_ctr, 32'd0);
        check("rst_chan",    eng_if.pipeline_chan, 2'd0);
        reset = 1'b1;
        tick();

        // Basic echo frame: 13 cycles, output equals input
        run_frame({16'h0100, 16'hFF00}, lat);
        check("basic_lat",   lat, 13);
        check("basic_out",   out_samples, {16'h0100, 16'hFF00});
        check("basic_ctr",   sample_ctr, 32'd1);
        check("basic_ready", ready, 1'b1);
        tick();
        check("basic_pulse", out_valid, 1'b0);
        check("basic_hold",  out_samples, {16'h0100, 16'hFF00});
        check("basic_rdy2",  ready, 1'b1);

        // Gain and mixer both transform: out = in ^ 00FF ^ FFFF = in ^ FF00
        gain_xor = 16'h00FF;
        mix_xor  = 16'hFFFF;
        run_frame({16'h8001, 16'h7FFE}, lat);
        check("xor_lat", lat, 13);
        check("xor_out", out_samples, {16'h7F01, 16'h80FE});
        check("xor_ctr", sample_ctr, 32'd2);
        gain_xor = '0;
        mix_xor  = '0;

        // Only pipeline 0 enabled; pipeline 1 never ready but is ignored
        en_val  = 2'b01;
        rdy_val = 2'b01;
        mix0    = mix_cnt;
        run_frame({16'h1111, 16'h2222}, lat);
        check("en01_lat", lat, 13);
        check("en01_mix", mix_cnt - mix0, 2);
        check("en01_tmo", timeout_flag, 1'b0);
        check("en01_out", out_samples, {16'h1111, 16'h2222});

        // Channel 1 stalls on enabled pipeline 0 -> dry bypass after 8 cycles
        en_val    = 2'b11;
        rdy_val   = 2'b11;
        stall_ch1 = 1'b1;
        mix_xor   = 16'h0F0F;
        mix0      = mix_cnt;
        proc0     = proc_cnt;
        run_frame({16'h1234, 16'h5555}, lat);
        check("tmo_lat",  lat, 19);
        check("tmo_out",  out_samples, {16'h1234, 16'h5A5A});
        check("tmo_mix",  mix_cnt - mix0, 1);
        check("tmo_proc", proc_cnt - proc0, 9);
        check("tmo_flag", timeout_flag, 1'b1);
        stall_ch1   = 1'b0;
        mix_xor     = '0;
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("tmo_clear", timeout_flag, 1'b0);

        // Three strobes mid-frame are dropped; first frame unaffected
        in_samples   = {16'hABCD, 16'h0042};
        sample_valid = 1'b1;
        tick();
        for (int i = 1; i <= 13; i++) begin
            sample_valid = (i == 2 || i == 5 || i == 8);
            in_samples   = sample_valid ? 32'hDEAD_BEEF : {16'hABCD, 16'h0042};
            tick();
        end
        sample_valid = 1'b0;
        check("ovr_valid", out_valid, 1'b1);
        check("ovr_out",   out_samples, {16'hABCD, 16'h0042});
        check("ovr_count", overrun_count, 8'd3);

        // Continuous strobes drive far more than 255 overruns
        in_samples   = 32'h0001_0002;
        sample_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        sample_valid = 1'b0;
        wait_ready();
        check("ovr_sat", overrun_count, 8'd255);

        // Clear together with an overrun: the overrun wins
        sample_valid = 1'b1;
        tick();
        clear_flags = 1'b1;
        tick();
        sample_valid = 1'b0;
        clear_flags  = 1'b0;
        check("ovr_clr_evt", overrun_count, 8'd1);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("ovr_frame_done", out_valid, 1'b1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("ovr_clr", overrun_count, 8'd0);

        // Reset while in MIX abandons the frame
        in_samples   = {16'h7777, 16'h6666};
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        n = 0;
        while (state_out != 3'd5 && n < 20) begin
            tick();
            n++;
        end
        check("mid_reach_mix", state_out, 3'd5);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_state",  state_out, 3'd0);
        check("mid_ready",  ready, 1'b1);
        check("mid_out",    out_samples, 32'h0);
        check("mid_mixreq", eng_if.mix_req, 1'b0);
        check("mid_ctr",    sample_ctr, 32'd0);
        run_frame({16'h0A0B, 16'h0C0D}, lat);
        check("mid_new_lat", lat, 13);
        check("mid_new_out", out_samples, {16'h0A0B, 16'h0C0D});
        check("mid_new_ctr", sample_ctr, 32'd1);

        // No pipelines enabled: PROCESS is one cycle per channel
        en_val  = 2'b00;
        rdy_val = 2'b00;
        proc0   = proc_cnt;
        run_frame({16'hFFFF, 16'h8000}, lat);
        check("en00_lat",  lat, 13);
        check("en00_proc", proc_cnt - proc0, 2);
        check("en00_out",  out_samples, {16'hFFFF, 16'h8000});
        check("en00_tmo",  timeout_flag, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/engine_sequencer.md
Name: engine_sequencer

Overview:
- Parametrised successor to the engine-level sample FSM.
- Sequences n_channels samples per frame through input gain, a bank of n_pipelines DSP pipelines and the output mixer, one channel at a time.
- Adds ignoring of disabled pipelines, a watchdog timeout with dry-sample bypass, overrun counting and frame status.
- Sits between the codec sample interface and the mixer/pipeline instances inside the engine.

Parameters:
data_width, 16, sample width in bits (signed)
n_channels, 2, samples per frame (>=1)
n_pipelines, 2, pipelines ticked in parallel (>=1)
timeout_cycles, 4096, maximum PROCESS-state wait before bypass (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
in_samples  in  n_channels*data_width  frame input; channel k occupies bits [k*data_width +: data_width]
sample_valid  in  1  frame strobe
out_samples  out  n_channels*data_width  last completed frame, same packing as in_samples
out_valid  out  1  one-cycle pulse when out_samples updates
ready  out  1  high only in IDLE
gain_req  out  1  one-cycle request to the gain stage
gain_sample  out  data_width  raw sample for the current channel
gain_done  in  1  gain result valid
gain_result  in  data_width  amplified sample
pipeline_tick  out  1  one-cycle tick to all pipelines
pipeline_in  out  data_width  amplified sample driven to the pipelines
pipeline_chan  out  $clog2(n_channels)+1  current channel index
pipeline_ready  in  n_pipelines  per-pipeline ready
pipeline_enable  in  n_pipelines  per-pipeline enable; disabled pipelines are ignored
mix_req  out  1  one-cycle request to the mixer
mix_done  in  1  mixer result valid
mix_result  in  data_width  mixed sample
timeout_flag  out  1  sticky; a PROCESS timeout occurred
overrun_count  out  8  saturating count of dropped frames
clear_flags  in  1  clears timeout_flag and overrun_count
sample_ctr  out  32  completed frames, wraps at 2^32
state_out  out  3  current state encoding

Behaviour:
- Reset values: out_samples=0, out_valid=0, ready=1, all *_req and pipeline_tick=0, timeout_flag=0, overrun_count=0, sample_ctr=0, channel index=0, state=IDLE.
- Reset mid-frame abandons the frame; out_samples retains no partial channel data (it is cleared to 0).
- State encodings: IDLE=0, GAIN=1, TICK=2, SETTLE=3, PROCESS=4, MIX=5, NEXT=6, DONE=7.
- IDLE:
  - On sample_valid, latch in_samples and set channel=0.
  - Assert gain_req on the next cycle with gain_sample set to channel 0. ready falls the same cycle.
  - Go to GAIN.
- GAIN: wait for gain_done. Latch gain_result into an internal amped register, then go to TICK. gain_done outside GAIN is ignored.
- TICK: assert pipeline_tick for exactly one cycle with pipeline_in=amped, then go to SETTLE.
- SETTLE: one fixed cycle, because pipelines drop ready one cycle after a tick. Clear the watchdog, then go to PROCESS.
- PROCESS: each cycle evaluate all_ok = &(pipeline_ready | ~pipeline_enable).
  - all_ok: pulse mix_req and go to MIX. This also applies with zero pipelines enabled, giving PROCESS latency 1.
  - Otherwise the watchdog increments. When it reaches timeout_cycles-1 without all_ok: channel result=amped (dry bypass), set timeout_flag, skip MIX, go to NEXT.
  - all_ok on the same cycle as watchdog expiry: all_ok wins.
- MIX: wait for mix_done, latch mix_result as the channel result, go to NEXT.
- NEXT: write the channel result into the out_samples staging register at the channel slot.
  - If channel==n_channels-1, go to DONE.
  - Otherwise increment channel, pulse gain_req and go to GAIN.
- DONE:
  - Copy staging into out_samples.
  - Pulse out_valid for one cycle.
  - sample_ctr += 1.
  - Go to IDLE with ready=1 on the next cycle.
- Out_samples changes only in the DONE cycle; it holds otherwise.
- Overrun: sample_valid in any state other than IDLE drops that frame and increments overrun_count, saturating at 255. The frame in flight is unaffected.
- clear_flags in the same cycle as a timeout or overrun event: the event wins, giving timeout_flag=1 or overrun_count=1.
- Per-channel latency with all pipelines ready and gain/mix answering in 1 cycle:
  - GAIN 1 + TICK 1 + SETTLE 1 + PROCESS 1 + MIX 1 + NEXT 1 = 6 cycles.
  - A full frame is 6*n_channels+1 cycles from the sample_valid edge to out_valid.

Test Plan:
- n_channels=2; gain and mixer echo their input after 1 cycle; both pipelines ready; in_samples={16'h0100,16'hFF00} -> out_valid 13 cycles after sample_valid, out_samples={16'h0100,16'hFF00}, sample_ctr=1, ready=1 next cycle.
- pipeline_enable=2'b01, pipeline_ready[1] held 0, pipeline_ready[0]=1 -> no timeout, mix_req issued for each channel, timeout_flag=0.
- timeout_cycles=8; pipeline_ready stuck at 0 on an enabled pipeline; channel amped value 16'h1234 -> PROCESS exits after 8 cycles, that channel's out value=16'h1234, no mix_req for it, timeout_flag=1; clear_flags -> 0.
- Three sample_valid pulses during a frame -> overrun_count=3 and the first frame completes correctly. Then 300 overruns -> overrun_count=255. clear_flags together with an overrun -> overrun_count=1.
- reset driven 0 while in MIX -> next cycle state_out=0, ready=1, out_samples=0, mix_req=0. A new frame then completes normally with sample_ctr=1.
- pipeline_enable=0 (no pipelines enabled) -> PROCESS lasts 1 cycle on each channel, and the frame completes in 13 cycles.
